rr_ack_arbiter_n: RTL and testbench

- Clocked, parametrised successor of the two-master acknowledge arbiter. One instance sits beside each slave.
- When the slave pulses ack_in, the block routes a single one-cycle acknowledge to exactly one of N_MAS masters. Eligible masters are those targeting this slave and waiting for an acknowledge (req_stat == W_ACK).
- Selection is round-robin by default, with an optional fixed-priority mode.
- An acknowledge that arrives with no eligible master is flagged and counted.

---
 rtl/rr_ack_arbiter_n_if.sv | 31 +++
 rtl/rr_ack_arbiter_n.sv | 113 +++++++++++
 tb/tb_rr_ack_arbiter_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rr_ack_arbiter_n_if.sv
// Bundle between one slave-side acknowledge arbiter and the logic around it:
// slave strobe and master status in, routed one-hot acknowledge and miss telemetry out.
interface rr_ack_arbiter_n_if #(
  parameter int N_MAS = 4,
  parameter int SLV_W = 1,
  parameter int CNT_W = 8
);
  localparam int IDX_W = (N_MAS > 1) ? $clog2(N_MAS) : 1;

  // Handshake: every cycle with ack_in high is one acknowledge, with no back-pressure.
  // It is answered on the same rising edge by either a one-cycle one-hot ack (with ack_vld)
  // or a one-cycle ack_miss; the receiving master must drop W_ACK itself once acked.
  logic                   ack_in;
  logic [N_MAS*SLV_W-1:0] sfor;
  logic [N_MAS*2-1:0]     req_stat;
  logic [N_MAS-1:0]       ack;
  logic                   ack_vld;
  logic [IDX_W-1:0]       grant_idx;
  logic                   ack_miss;
  logic [CNT_W-1:0]       miss_cnt;

  modport master (
    output ack_in, sfor, req_stat,
    input  ack, ack_vld, grant_idx, ack_miss, miss_cnt
  );

  modport slave (
    input  ack_in, sfor, req_stat,
    output ack, ack_vld, grant_idx, ack_miss, miss_cnt
  );
endinterface

// File: rtl/rr_ack_arbiter_n.sv
// Routes each slave acknowledge strobe to one eligible master (round-robin or
// fixed priority), flagging and counting strobes that find nobody waiting.
module rr_ack_arbiter_n #(
  parameter int N_MAS     = 4,
  parameter int SLV_W     = 1,
  parameter int SLV_ID    = 0,
  parameter int FIXED_PRI = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_ack_arbiter_n_if.slave bus
);
  localparam int IDX_W = (N_MAS > 1) ? $clog2(N_MAS) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MAS - 1);
  // An SLV_ID that cannot be encoded in SLV_W bits can never be selected.
  localparam bit ID_FITS = (SLV_ID >= 0) && ((SLV_W >= 31) || (SLV_ID < (1 << SLV_W)));
  localparam logic [SLV_W-1:0] SLV_ID_V = SLV_W'(SLV_ID);

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } req_e;

  logic [N_MAS-1:0] elig;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  logic [N_MAS-1:0] ack_q, ack_d;
  logic             ack_vld_q, ack_vld_d;
  logic             ack_miss_q, ack_miss_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_MAS; i++) begin
      elig[i] = ID_FITS
              && (bus.sfor[i*SLV_W +: SLV_W] == SLV_ID_V)
              && (bus.req_stat[i*2 +: 2] == W_ACK);
    end
  end

  // Round-robin walks last+1 .. last (wrapping); fixed priority walks 0 .. N_MAS-1.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N_MAS; off++) begin
      if (FIXED_PRI != 0) begin
        cand = off;
      end else begin
        cand = int'(last_q) + 1 + off;
        if (cand >= N_MAS) cand = cand - N_MAS;
      end
      cand_idx = IDX_W'(cand);
      if (!found && elig[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  always_comb begin
    ack_d      = '0;
    ack_vld_d  = 1'b0;
    ack_miss_d = 1'b0;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    if (bus.ack_in) begin
      if (found) begin
        ack_d[win] = 1'b1;
        ack_vld_d  = 1'b1;
        grant_d    = win;
        last_d     = win;
      end else begin
        ack_miss_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= '0;
      ack_vld_q  <= 1'b0;
      ack_miss_q <= 1'b0;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
    end else begin
      ack_q      <= ack_d;
      ack_vld_q  <= ack_vld_d;
      ack_miss_q <= ack_miss_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.ack_vld   = ack_vld_q;
  assign bus.grant_idx = grant_q;
  assign bus.ack_miss  = ack_miss_q;
  assign bus.miss_cnt  = cnt_q;
endmodule

// File: tb/tb_rr_ack_arbiter_n.sv
// Directed checks of the acknowledge arbiter: round-robin, fixed-priority
// and narrow-counter instances driven with identical stimulus.
module tb_rr_ack_arbiter_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_ack_arbiter_n_if #(.N_MAS(4), .SLV_W(1), .CNT_W(8)) if_rr ();
  rr_ack_arbiter_n_if #(.N_MAS(4), .SLV_W(1), .CNT_W(8)) if_fp ();
  rr_ack_arbiter_n_if #(.N_MAS(4), .SLV_W(1), .CNT_W(2)) if_sat ();

  rr_ack_arbiter_n #(.N_MAS(4), .SLV_W(1), .SLV_ID(0), .FIXED_PRI(0), .CNT_W(8))
    u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  rr_ack_arbiter_n #(.N_MAS(4), .SLV_W(1), .SLV_ID(0), .FIXED_PRI(1), .CNT_W(8))
    u_fp (.clk(clk), .rst(rst), .bus(if_fp));
  rr_ack_arbiter_n #(.N_MAS(4), .SLV_W(1), .SLV_ID(0), .FIXED_PRI(0), .CNT_W(2))
    u_sat (.clk(clk), .rst(rst), .bus(if_sat));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus to all three instances; sfor is one bit per master here.
  task automatic apply(input logic a, input logic [3:0] s, input logic [7:0] r);
    if_rr.ack_in  = a; if_rr.sfor  = s; if_rr.req_stat  = r;
    if_fp.ack_in  = a; if_fp.sfor  = s; if_fp.req_stat  = r;
    if_sat.ack_in = a; if_sat.sfor = s; if_sat.req_stat = r;
  endtask

  localparam logic [7:0] ALL_WACK = 8'b10_10_10_10;

  initial begin
    logic [3:0] exp_rr [5];
    logic [3:0] exp_g  [5];
    logic [3:0] exp_rr2[3];
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_g   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    exp_rr2 = '{4'b1000, 4'b0010, 4'b1000};

    apply(1'b0, 4'b0000, 8'h00);
    step();
    step();
    check("rst_ack",   32'(if_rr.ack), 32'h0);
    check("rst_vld",   32'(if_rr.ack_vld), 32'h0);
    check("rst_miss",  32'(if_rr.ack_miss), 32'h0);
    check("rst_cnt",   32'(if_rr.miss_cnt), 32'h0);
    check("rst_grant", 32'(if_rr.grant_idx), 32'h0);
    rst = 1'b0;

    // All four eligible, five back-to-back strobes.
    apply(1'b1, 4'b0000, ALL_WACK);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_all_ack",   32'(if_rr.ack), 32'(exp_rr[i]));
      check("rr_all_grant", 32'(if_rr.grant_idx), 32'(exp_g[i]));
      check("rr_all_vld",   32'(if_rr.ack_vld), 32'h1);
      check("fp_all_ack",   32'(if_fp.ack), 32'h1);
    end
    apply(1'b0, 4'b0000, ALL_WACK);
    step();
    check("idle_ack",   32'(if_rr.ack), 32'h0);
    check("idle_vld",   32'(if_rr.ack_vld), 32'h0);
    check("idle_grant", 32'(if_rr.grant_idx), 32'h0);

    // Only master 2 eligible: once to set last=2, again with last=2.
    apply(1'b1, 4'b0000, 8'b00_10_00_00);
    step();
    check("m2_ack",   32'(if_rr.ack), 32'b0100);
    check("m2_grant", 32'(if_rr.grant_idx), 32'd2);
    step();
    check("m2_last_ack",   32'(if_rr.ack), 32'b0100);
    check("m2_last_grant", 32'(if_rr.grant_idx), 32'd2);
    apply(1'b0, 4'b0000, 8'b00_10_00_00);
    step();
    check("m2_one_cycle", 32'(if_rr.ack), 32'h0);

    // m0 W_DATA, m1 W_ACK here, m3 W_ACK for another slave.
    apply(1'b1, 4'b1000, 8'b10_00_10_11);
    step();
    check("sel_ack1",   32'(if_rr.ack), 32'b0010);
    check("sel_grant1", 32'(if_rr.grant_idx), 32'd1);
    step();
    check("sel_ack2",   32'(if_rr.ack), 32'b0010);
    check("sel_fp_ack", 32'(if_fp.ack), 32'b0010);

    // Nobody eligible: five misses, narrow counter saturates at 3.
    apply(1'b1, 4'b0000, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("miss_ack",   32'(if_rr.ack), 32'h0);
      check("miss_vld",   32'(if_rr.ack_vld), 32'h0);
      check("miss_pulse", 32'(if_rr.ack_miss), 32'h1);
      check("miss_cnt",   32'(if_rr.miss_cnt), 32'(i));
      check("miss_grant", 32'(if_rr.grant_idx), 32'd1);
      check("sat_cnt",    32'(if_sat.miss_cnt), 32'((i < 3) ? i : 3));
    end
    apply(1'b0, 4'b0000, 8'h00);
    step();
    check("miss_clear",     32'(if_rr.ack_miss), 32'h0);
    check("miss_cnt_hold",  32'(if_rr.miss_cnt), 32'd5);

    // Masters 1 and 3 eligible: fixed priority sticks to 1, round-robin alternates.
    apply(1'b1, 4'b0000, 8'b10_00_10_00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_13_ack", 32'(if_fp.ack), 32'b0010);
      check("rr_13_ack", 32'(if_rr.ack), 32'(exp_rr2[i]));
    end

    // Grant master 1, then reset while that pulse is visible.
    apply(1'b1, 4'b0000, 8'b00_00_10_00);
    step();
    check("pre_rst_ack", 32'(if_rr.ack), 32'b0010);
    apply(1'b1, 4'b0000, ALL_WACK);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack",   32'(if_rr.ack), 32'h0);
    check("async_rst_grant", 32'(if_rr.grant_idx), 32'h0);
    check("async_rst_cnt",   32'(if_rr.miss_cnt), 32'h0);
    step();
    check("rst_hold_ack", 32'(if_rr.ack), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_ack",   32'(if_rr.ack), 32'b0001);
    check("post_rst_grant", 32'(if_rr.grant_idx), 32'd0);
    check("post_rst_fp",    32'(if_fp.ack), 32'b0001);
    apply(1'b0, 4'b0000, 8'h00);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
